// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM for the 16-bit CPU: sequences FETCH/DECODE/EXEC/MEM/WB/BRANCH,
// drives datapath selects and strobes per state, stalls on MemReady and traps illegal opcodes.
module multicycle_control_unit #(
    parameter int OPCODE_W = 3,
    parameter int OP_RTYPE = 0,
    parameter int OP_BEQ   = 1,
    parameter int OP_ADDI  = 3,
    parameter int OP_SLTI  = 4,
    parameter int OP_LW    = 5,
    parameter int OP_SW    = 6,
    parameter int OP_BNE   = 7
) (
    input  logic                Clock,
    input  logic                Reset_n,
    input  logic                Enable,
    input  logic [OPCODE_W-1:0] OPCODE,
    input  logic                MemReady,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                BranchNe,
    output logic                PCSource,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                RegDst,
    output logic                MemToReg,
    output logic                RegWrite,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          ALUOp,
    output logic                Illegal,
    output logic [2:0]          StateOut
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_BRANCH = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    localparam logic [OPCODE_W-1:0] OpR    = OPCODE_W'(OP_RTYPE);
    localparam logic [OPCODE_W-1:0] OpBeq  = OPCODE_W'(OP_BEQ);
    localparam logic [OPCODE_W-1:0] OpAddi = OPCODE_W'(OP_ADDI);
    localparam logic [OPCODE_W-1:0] OpSlti = OPCODE_W'(OP_SLTI);
    localparam logic [OPCODE_W-1:0] OpLw   = OPCODE_W'(OP_LW);
    localparam logic [OPCODE_W-1:0] OpSw   = OPCODE_W'(OP_SW);
    localparam logic [OPCODE_W-1:0] OpBne  = OPCODE_W'(OP_BNE);

    state_t state_q, state_d;
    logic   illegal_q, illegal_d;

    logic isR, isImm, isMem, isBranch;
    assign isR      = (OPCODE == OpR);
    assign isImm    = (OPCODE == OpAddi) || (OPCODE == OpSlti);
    assign isMem    = (OPCODE == OpLw) || (OPCODE == OpSw);
    assign isBranch = (OPCODE == OpBeq) || (OPCODE == OpBne);

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        BranchNe    = 1'b0;
        PCSource    = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegDst      = 1'b0;
        MemToReg    = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;

        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = MemReady;
                PCWrite = MemReady;
                if (MemReady) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                if (isBranch)                 state_d = S_BRANCH;
                else if (isR || isImm || isMem) state_d = S_EXEC;
                else                          state_d = S_TRAP;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                if (isR) begin
                    ALUOp   = 2'b10;
                    state_d = S_WB;
                end else if (isImm) begin
                    ALUSrcB = 2'b10;
                    ALUOp   = 2'b11;
                    state_d = S_WB;
                end else if (isMem) begin
                    ALUSrcB = 2'b10;
                    state_d = S_MEM;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEM: begin
                IorD = 1'b1;
                if (OPCODE == OpLw) begin
                    MemRead = 1'b1;
                    if (MemReady) state_d = S_WB;
                end else if (OPCODE == OpSw) begin
                    MemWrite = 1'b1;
                    if (MemReady) state_d = S_FETCH;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_WB: begin
                RegWrite = 1'b1;
                RegDst   = isR;
                MemToReg = (OPCODE == OpLw);
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 1'b1;
                BranchNe    = (OPCODE == OpBne);
                state_d     = S_FETCH;
            end
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase

        // A stalled or resetting FSM must never issue a write or memory request.
        if (!Enable || !Reset_n) begin
            state_d     = state_q;
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            RegWrite    = 1'b0;
        end
        if (!Reset_n) begin
            BranchNe = 1'b0;
            PCSource = 1'b0;
            IorD     = 1'b0;
            RegDst   = 1'b0;
            MemToReg = 1'b0;
            ALUSrcA  = 1'b0;
            ALUSrcB  = 2'b00;
            ALUOp    = 2'b00;
        end
    end

    assign illegal_d = illegal_q || (state_d == S_TRAP);
    assign Illegal   = illegal_q;
    assign StateOut  = state_q;

endmodule
